// File: rtl/servo_pkg.sv
// Shared constants and state type for the servo PWM generator.
package servo_pkg;

  // Default timing, in divided-clock ticks (~128 kHz tick).
  localparam int unsigned FRAME_TICKS     = 2558;  // ~20 ms frame
  localparam int unsigned MIN_PULSE_TICKS = 128;   // ~1 ms at position 0
  localparam int unsigned MAX_POS         = 128;   // ~2 ms at MAX_POS
  localparam int unsigned POS_WIDTH       = 8;
  localparam int unsigned RESET_POS       = 64;    // centre
  localparam int unsigned SLEW_STEP       = 4;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } servo_state_e;

endpackage

// File: rtl/servo_tick_detect.sv
// Rising-edge detector for the divided-clock level from the upstream divider.
module servo_tick_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic tick_in,
  output logic tick_pulse
);

  logic tick_prev_q;

  // Remember last cycle's tick level.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick_prev_q <= 1'b0;
    end else begin
      tick_prev_q <= tick_in;
    end
  end

  assign tick_pulse = tick_in & ~tick_prev_q;

endmodule

// File: rtl/servo_pwm_generator.sv
// RC servo PWM generator. Position commands are buffered in a one-entry
// pending register and applied only on frame boundaries.
// Optional feature: define SERVO_SLEW_LIMIT_EN to limit the per-frame
// position change to SLEW_STEP.
module servo_pwm_generator #(
  parameter int unsigned FRAME_TICKS     = servo_pkg::FRAME_TICKS,
  parameter int unsigned MIN_PULSE_TICKS = servo_pkg::MIN_PULSE_TICKS,
  parameter int unsigned MAX_POS         = servo_pkg::MAX_POS,
  parameter int unsigned POS_WIDTH       = servo_pkg::POS_WIDTH,
  parameter int unsigned RESET_POS       = servo_pkg::RESET_POS,
  parameter int unsigned SLEW_STEP       = servo_pkg::SLEW_STEP
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 tick_in,
  input  logic [POS_WIDTH-1:0] pos_data,
  input  logic                 pos_valid,
  output logic                 pos_ready,
  output logic                 pwm_out,
  output logic                 frame_start,
  output logic [POS_WIDTH-1:0] cur_pos
);

  import servo_pkg::*;

  localparam int unsigned CntW = $clog2(FRAME_TICKS);

  logic tick_pulse;

  servo_tick_detect u_tick_detect (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick_in    (tick_in),
    .tick_pulse (tick_pulse)
  );

  servo_state_e         state_q, state_d;
  logic [CntW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [CntW-1:0]      pulse_ticks_q, pulse_ticks_d;
  logic [POS_WIDTH-1:0] pending_q, pending_d;
  logic [POS_WIDTH-1:0] target_q, target_d;
  logic [POS_WIDTH-1:0] cur_pos_q, cur_pos_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 pwm_q, frame_start_q;
  logic                 boundary;
  logic                 accept;
  logic [POS_WIDTH-1:0] pos_sat;

  // Held low during reset so no command is accepted while state is clearing.
  assign pos_ready = reset_n & ~pending_valid_q;
  assign accept    = pos_valid & pos_ready;
  assign pos_sat   = (pos_data > POS_WIDTH'(MAX_POS)) ? POS_WIDTH'(MAX_POS) : pos_data;

`ifdef SERVO_SLEW_LIMIT_EN
  function automatic logic [POS_WIDTH-1:0] slew_toward(input logic [POS_WIDTH-1:0] cur,
                                                       input logic [POS_WIDTH-1:0] tgt);
    if (tgt > cur) begin
      return ((tgt - cur) > POS_WIDTH'(SLEW_STEP)) ? cur + POS_WIDTH'(SLEW_STEP) : tgt;
    end else begin
      return ((cur - tgt) > POS_WIDTH'(SLEW_STEP)) ? cur - POS_WIDTH'(SLEW_STEP) : tgt;
    end
  endfunction
`else
  logic unused_slew_step;
  assign unused_slew_step = ^SLEW_STEP;
`endif

  // Next-state: frame sequencing, pending buffer and boundary updates.
  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    pulse_ticks_d   = pulse_ticks_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    target_d        = target_q;
    cur_pos_d       = cur_pos_q;
    boundary        = 1'b0;

    if (tick_pulse) begin
      unique case (state_q)
        IDLE: begin
          boundary = 1'b1;
          state_d  = HIGH;
        end
        HIGH: begin
          tick_cnt_d = tick_cnt_q + CntW'(1);
          if ((tick_cnt_q + CntW'(1)) == pulse_ticks_q) begin
            state_d = LOW;
          end
        end
        LOW: begin
          if (tick_cnt_q == CntW'(FRAME_TICKS - 1)) begin
            boundary = 1'b1;
            state_d  = HIGH;
          end else begin
            tick_cnt_d = tick_cnt_q + CntW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (boundary) begin
      tick_cnt_d = '0;
      if (pending_valid_q) begin
        target_d        = pending_q;
        pending_valid_d = 1'b0;
      end
`ifdef SERVO_SLEW_LIMIT_EN
      cur_pos_d = slew_toward(cur_pos_q, target_d);
`else
      cur_pos_d = target_d;
`endif
      pulse_ticks_d = CntW'(MIN_PULSE_TICKS) + CntW'(cur_pos_d);
    end

    // A boundary in the same cycle only saw the old (empty) buffer.
    if (accept) begin
      pending_d       = pos_sat;
      pending_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      tick_cnt_q      <= '0;
      pulse_ticks_q   <= CntW'(MIN_PULSE_TICKS + RESET_POS);
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      target_q        <= POS_WIDTH'(RESET_POS);
      cur_pos_q       <= POS_WIDTH'(RESET_POS);
      pwm_q           <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      pulse_ticks_q   <= pulse_ticks_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      target_q        <= target_d;
      cur_pos_q       <= cur_pos_d;
      pwm_q           <= (state_d == HIGH);
      frame_start_q   <= boundary;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign cur_pos     = cur_pos_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Directed bench for servo_pwm_generator. Ticks arrive every 2 clocks so a
// 2558-tick frame lasts 5116 clocks.
module tb_servo_pwm_generator;

`ifdef SERVO_SLEW_LIMIT_EN
  localparam int E3 = 60;
  localparam int E4 = 64;
  localparam int E5 = 68;
  localparam int E6 = 64;
  localparam int E7 = 68;
  localparam int E8 = 72;
`else
  localparam int E3 = 0;
  localparam int E4 = 128;
  localparam int E5 = 128;
  localparam int E6 = 32;
  localparam int E7 = 128;
  localparam int E8 = 128;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick_in;
  logic [7:0] pos_data;
  logic       pos_valid;
  logic       pos_ready;
  logic       pwm_out;
  logic       frame_start;
  logic [7:0] cur_pos;

  bit tick_en = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0, rise_cyc = 0, fs_cyc = 0;
  int high_ticks = -1, frame_ticks = -1;
  bit have_fs = 1'b0, pwm_prev = 1'b0;

  servo_pwm_generator dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tick_in     (tick_in),
    .pos_data    (pos_data),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .cur_pos     (cur_pos)
  );

  always #5 clock = ~clock;

  // Divided-clock level: toggles every clock while enabled.
  initial begin
    tick_in = 1'b0;
    forever begin
      @(negedge clock);
      tick_in = tick_en ? ~tick_in : 1'b0;
    end
  end

  // Measure pulse widths and frame lengths in ticks.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (!reset_n) have_fs = 1'b0;
      if (pwm_out && !pwm_prev) rise_cyc = cyc;
      if (!pwm_out && pwm_prev) high_ticks = (cyc - rise_cyc) / 2;
      if (frame_start) begin
        if (have_fs) frame_ticks = (cyc - fs_cyc) / 2;
        fs_cyc  = cyc;
        have_fs = 1'b1;
      end
      pwm_prev = pwm_out;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    @(negedge clock);
    while (!frame_start && n < 6000) begin
      @(negedge clock);
      n++;
    end
    if (!frame_start) check_eq({tag, " frame_start timeout"}, 0, 1);
  endtask

  task automatic send_pos(input logic [7:0] val, input string tag);
    check_eq({tag, " ready before"}, int'(pos_ready), 1);
    pos_data  = val;
    pos_valid = 1'b1;
    @(negedge clock);
    pos_valid = 1'b0;
    check_eq({tag, " ready after"}, int'(pos_ready), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    pos_data  = 8'd0;
    pos_valid = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("rst pwm", int'(pwm_out), 0);
    check_eq("rst frame_start", int'(frame_start), 0);
    check_eq("rst ready", int'(pos_ready), 0);
    check_eq("rst cur_pos", int'(cur_pos), 64);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("idle ready", int'(pos_ready), 1);
    check_eq("idle pwm", int'(pwm_out), 0);

    tick_en = 1'b1;
    wait_fs("f1");
    check_eq("f1 cur_pos", int'(cur_pos), 64);
    check_eq("f1 pwm", int'(pwm_out), 1);

    wait_fs("f2");
    check_eq("f1 high", high_ticks, 192);
    check_eq("f1 frame", frame_ticks, 2558);
    repeat (100) @(negedge clock);
    send_pos(8'd0, "pos0");
    check_eq("pos0 cur_pos held", int'(cur_pos), 64);

    wait_fs("f3");
    check_eq("f2 high", high_ticks, 192);
    check_eq("f2 frame", frame_ticks, 2558);
    check_eq("f3 cur_pos", int'(cur_pos), E3);
    check_eq("f3 ready", int'(pos_ready), 1);
    repeat (100) @(negedge clock);
    send_pos(8'd200, "pos200");

    wait_fs("f4");
    check_eq("f3 high", high_ticks, 128 + E3);
    check_eq("f4 cur_pos", int'(cur_pos), E4);

    // Handshake in the very cycle of the next boundary tick.
    repeat (5115) @(negedge clock);
    check_eq("bnd ready before", int'(pos_ready), 1);
    pos_data  = 8'd32;
    pos_valid = 1'b1;
    @(negedge clock);
    pos_valid = 1'b0;
    check_eq("bnd frame_start", int'(frame_start), 1);
    check_eq("bnd ready after", int'(pos_ready), 0);
    check_eq("f5 cur_pos", int'(cur_pos), E5);
    check_eq("f4 high", high_ticks, 128 + E4);

    wait_fs("f6");
    check_eq("f5 high", high_ticks, 128 + E5);
    check_eq("f5 frame", frame_ticks, 2558);
    check_eq("f6 cur_pos", int'(cur_pos), E6);
    check_eq("f6 ready", int'(pos_ready), 1);
    repeat (100) @(negedge clock);
    send_pos(8'd128, "pos128");

    wait_fs("f7");
    check_eq("f6 high", high_ticks, 128 + E6);
    check_eq("f7 cur_pos", int'(cur_pos), E7);

    wait_fs("f8");
    check_eq("f7 high", high_ticks, 128 + E7);
    check_eq("f8 cur_pos", int'(cur_pos), E8);

    // Reset in the middle of the high phase.
    repeat (50) @(negedge clock);
    check_eq("pre-rst pwm", int'(pwm_out), 1);
    reset_n = 1'b0;
    tick_en = 1'b0;
    @(negedge clock);
    check_eq("mid rst pwm", int'(pwm_out), 0);
    check_eq("mid rst cur_pos", int'(cur_pos), 64);
    check_eq("mid rst ready", int'(pos_ready), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("post rst pwm", int'(pwm_out), 0);
    tick_en = 1'b1;
    wait_fs("r1");
    check_eq("r1 cur_pos", int'(cur_pos), 64);
    wait_fs("r2");
    check_eq("r1 high", high_ticks, 192);
    check_eq("r1 frame", frame_ticks, 2558);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
